// File: rtl/intexp.sv
// Sequential integer expander: sign-extends a narrow signed value and shifts it
// left one bit per cycle, clamping to the wide signed range on overflow.
module intexp #(
    parameter int unsigned IN_LEN    = 32,
    parameter int unsigned OUT_LEN   = 64,
    parameter int unsigned SHIFT_WID = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic signed [IN_LEN-1:0]  inp,
    input  logic [SHIFT_WID-1:0]      shift,
    output logic signed [OUT_LEN-1:0] outp,
    output logic                      finished,
    output logic                      saturated
);

    typedef enum logic [1:0] {
        WAIT,
        SHIFTING,
        DONE
    } state_e;

    localparam logic [OUT_LEN-1:0] MAX_POS = {1'b0, {(OUT_LEN-1){1'b1}}};
    localparam logic [OUT_LEN-1:0] MAX_NEG = {1'b1, {(OUT_LEN-1){1'b0}}};

    state_e               state_q, state_d;
    logic [OUT_LEN-1:0]   acc_q, acc_d;
    logic [SHIFT_WID-1:0] cnt_q, cnt_d;
    logic [OUT_LEN-1:0]   outp_q, outp_d;
    logic                 sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        outp_d  = outp_q;
        sat_d   = sat_q;
        case (state_q)
            WAIT: begin
                if (arm) begin
                    acc_d   = {{(OUT_LEN-IN_LEN){inp[IN_LEN-1]}}, inp};
                    cnt_d   = shift;
                    sat_d   = 1'b0;
                    state_d = SHIFTING;
                end
            end
            SHIFTING: begin
                if (cnt_q == '0) begin
                    outp_d  = acc_q;
                    state_d = DONE;
                end else if (acc_q[OUT_LEN-1] == acc_q[OUT_LEN-2]) begin
                    // Top two bits equal: one more left shift keeps the sign.
                    acc_d = {acc_q[OUT_LEN-2:0], 1'b0};
                    cnt_d = cnt_q - SHIFT_WID'(1);
                end else begin
                    acc_d   = acc_q[OUT_LEN-1] ? MAX_NEG : MAX_POS;
                    outp_d  = acc_q[OUT_LEN-1] ? MAX_NEG : MAX_POS;
                    sat_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!arm) begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            acc_q   <= '0;
            cnt_q   <= '0;
            outp_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            outp_q  <= outp_d;
            sat_q   <= sat_d;
        end
    end

    assign outp      = outp_q;
    assign finished  = (state_q == DONE);
    assign saturated = sat_q;

endmodule

// File: tb/tb_intexp.sv
// Scoreboard bench for intexp: driver pushes model expectations, monitor pops
// them when finished rises and checks value, saturation flag and latency.
module tb_intexp;

    localparam int unsigned IN_LEN    = 8;
    localparam int unsigned OUT_LEN   = 16;
    localparam int unsigned SHIFT_WID = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      arm;
    logic signed [IN_LEN-1:0]  inp;
    logic [SHIFT_WID-1:0]      shift;
    logic signed [OUT_LEN-1:0] outp;
    logic                      finished;
    logic                      saturated;

    always #5 clk = ~clk;

    intexp #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT_WID(SHIFT_WID)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .inp       (inp),
        .shift     (shift),
        .outp      (outp),
        .finished  (finished),
        .saturated (saturated)
    );

    typedef struct {
        logic [OUT_LEN-1:0] outp;
        logic               sat;
        int unsigned        lat;
        int unsigned        k;
    } exp_t;

    exp_t               sb[$];
    int unsigned        checks = 0;
    int unsigned        errors = 0;
    int unsigned        cyc = 0;
    logic [OUT_LEN-1:0] exp_hold = '0;
    logic               fin_prev = 1'b0;
    logic               rst_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: value = inp * 2^shift clamped to the signed range; latency is
    // one plus the number of shifts that still fit in the output range.
    function automatic exp_t model(input logic signed [IN_LEN-1:0] v, input logic [SHIFT_WID-1:0] s);
        exp_t        e;
        longint      hi;
        longint      lo;
        longint      full;
        longint      p;
        int unsigned legal;
        hi    = (longint'(1) <<< (OUT_LEN-1)) - 1;
        lo    = -(longint'(1) <<< (OUT_LEN-1));
        full  = longint'(v) * (longint'(1) <<< s);
        e.sat = (full > hi) || (full < lo);
        legal = 0;
        for (int i = 1; i <= int'(s); i++) begin
            p = longint'(v) * (longint'(1) <<< i);
            if (p <= hi && p >= lo) legal++;
        end
        if (!e.sat)     e.outp = full[OUT_LEN-1:0];
        else if (v < 0) e.outp = {1'b1, {(OUT_LEN-1){1'b0}}};
        else            e.outp = {1'b0, {(OUT_LEN-1){1'b1}}};
        e.lat = legal + 1;
        e.k   = 0;
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            if (rst_e) begin
                exp_hold = '0;
                fin_prev = 1'b0;
            end
            if (finished && !fin_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_finish", 32'(finished), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("outp", {16'b0, outp}, {16'b0, e.outp});
                    chk("saturated", 32'(saturated), 32'(e.sat));
                    chk("latency", cyc - e.k, e.lat);
                    exp_hold = e.outp;
                end
            end else if (!finished) begin
                chk("outp_hold", {16'b0, outp}, {16'b0, exp_hold});
            end
            fin_prev = finished;
        end
    end

    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        arm = 1'b1;
        @(negedge clk);
        chk({tag, "_outp"}, {16'b0, outp}, 32'(0));
        chk({tag, "_finished"}, 32'(finished), 32'(0));
        chk({tag, "_saturated"}, 32'(saturated), 32'(0));
        rst = 1'b0;
        arm = 1'b0;
    endtask

    task automatic run(input int v, input int unsigned s, input int unsigned hold);
        exp_t                     e;
        bit                       seen;
        logic signed [IN_LEN-1:0] vi;
        logic [SHIFT_WID-1:0]     si;
        vi = IN_LEN'(v);
        si = SHIFT_WID'(s);
        @(negedge clk);
        chk("idle_finished", 32'(finished), 32'(0));
        inp   = vi;
        shift = si;
        arm   = 1'b1;
        @(negedge clk);
        e   = model(vi, si);
        e.k = cyc;
        sb.push_back(e);
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (finished) begin
                seen = 1'b1;
                break;
            end
            // Inputs during the conversion must have no effect.
            arm   = 1'($urandom_range(0, 1));
            inp   = IN_LEN'($urandom);
            shift = SHIFT_WID'($urandom);
            @(negedge clk);
        end
        if (!seen) begin
            chk("finish_timeout", 32'(finished), 32'(1));
            if (sb.size() > 0) void'(sb.pop_back());
            rst_pulse("timeout_rst");
        end else begin
            arm = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("done_hold", 32'(finished), 32'(1));
            end
            arm = 1'b0;
        end
    endtask

    task automatic abort_run();
        @(negedge clk);
        inp   = 8'sd1;
        shift = 4'd15;
        arm   = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        rst_pulse("abort");
    endtask

    initial begin : driver
        rst   = 1'b1;
        arm   = 1'b1;
        inp   = '0;
        shift = '0;
        repeat (3) @(negedge clk);
        chk("reset_outp", {16'b0, outp}, 32'(0));
        chk("reset_finished", 32'(finished), 32'(0));
        chk("reset_saturated", 32'(saturated), 32'(0));
        rst = 1'b0;
        arm = 1'b0;

        run(3, 4, 0);
        run(-128, 8, 2);
        run(127, 9, 1);
        @(negedge clk);
        rst_pulse("wait_rst");
        run(-5, 0, 0);
        run(-1, 15, 3);
        run(0, 15, 1);
        abort_run();
        run(3, 4, 0);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) run(0, $urandom_range(0, 15), $urandom_range(0, 3));
            else run(int'($urandom_range(0, 255)) - 128, $urandom_range(0, 15), $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intexp.md
INTEXP -- requirements
Module: intexp

Interface
REQ-001 The block SHALL have parameter IN_LEN, default 32, meaning the width of the signed narrow input.
REQ-002 The block SHALL have parameter OUT_LEN, default 64, meaning the width of the signed wide output; OUT_LEN > IN_LEN.
REQ-003 The block SHALL have parameter SHIFT_WID, default 6, meaning the width of the shift-amount port.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port arm, input, 1 bit: request to start one conversion.
REQ-007 The block SHALL have port inp, input, signed IN_LEN bits: the two's-complement value to expand.
REQ-008 The block SHALL have port shift, input, SHIFT_WID bits, unsigned: the left-shift amount.
REQ-009 The block SHALL have port outp, output, signed OUT_LEN bits: the expanded result, equal to inp * 2^shift, saturated.
REQ-010 The block SHALL have port finished, output, 1 bit: high while outp holds a valid result.
REQ-011 The block SHALL have port saturated, output, 1 bit: high with finished when the result was clamped.

Function
REQ-012 The block SHALL implement three states: WAIT, SHIFTING and DONE.
REQ-013 In WAIT, when arm is sampled high at edge k, the block SHALL latch inp sign-extended to OUT_LEN into the accumulator, latch shift into the counter, clear saturated, and enter SHIFTING.
REQ-014 In SHIFTING with counter != 0 and accumulator bits [OUT_LEN-1] == [OUT_LEN-2], the block SHALL shift the accumulator left by one (LSB filled with 0) and decrement the counter.
REQ-015 In SHIFTING with counter != 0 and accumulator bits [OUT_LEN-1] != [OUT_LEN-2], the block SHALL load 0x7FF..F if the accumulator sign is 0, or 0x800..0 if it is 1, set saturated, and enter DONE.
REQ-016 In SHIFTING with counter == 0, the block SHALL enter DONE.
REQ-017 Unsaturated latency SHALL be exact: finished rises after edge k+shift+1, including shift = 0 (after edge k+1).
REQ-018 When saturation occurs, finished SHALL rise on the edge following the last legal shift, before the counter expires.
REQ-019 In DONE, finished SHALL be 1 and outp SHALL equal the accumulator. The block SHALL remain in DONE while arm is high and return to WAIT on the first edge where arm is low.
REQ-020 Holding arm high SHALL NOT start a second conversion; arm must be seen low before a new one starts.
REQ-021 Changes to inp, shift or arm while in SHIFTING SHALL be ignored.
REQ-022 In WAIT and SHIFTING, finished SHALL be 0. outp SHALL hold its last value and SHALL NOT show intermediate accumulator values.
REQ-023 Shift amounts that exceed the available headroom, up to 2^SHIFT_WID-1, SHALL produce a saturated result. A zero input SHALL never saturate.

Reset
REQ-024 When rst is high at an edge, in any state including mid-SHIFTING, the block SHALL enter WAIT and clear the accumulator, counter, outp, finished and saturated to 0.
REQ-025 arm SHALL be ignored on any edge where rst is high.

Structure
REQ-026 State encodings SHALL be local constants of this module; no shared package is required.
REQ-027 The block SHALL be one flat module with no sub-modules.

Verification (bench: IN_LEN=8, OUT_LEN=16, SHIFT_WID=4)
REQ-028 inp=3, shift=4, arm pulse at edge k -> outp=48, saturated=0, finished rising after edge k+5.
REQ-029 inp=-128, shift=8 -> outp=0x8000, saturated=0, finished after edge k+9.
REQ-030 inp=127, shift=9 -> outp=0x7FFF, saturated=1, finished after edge k+9 (clamped at the 9th shift).
REQ-031 inp=-5, shift=0 -> outp=0xFFFB, finished after edge k+1. Then inp=-1, shift=15 -> outp=0x8000, saturated=0.
REQ-032 arm held high through DONE -> no restart; arm low for 1 cycle then high -> new conversion starts.
REQ-033 rst asserted during SHIFTING -> state WAIT and outp=0, finished=0, saturated=0 after that edge; the next arm completes normally.
